// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display scheduler slice.
//   BLANK_CODE / DASH_CODE : 4-bit digit codes understood by the scan driver
//   BLANK_WORD             : 16-bit bus word with all four digits switched off
//   state_t                : scheduler states (IDLE = nobody owns the display,
//                            SHOW = one source owns it)
// ---------------------------------------------------------------------------
package seg_pkg;

   localparam logic [3:0]  BLANK_CODE = 4'hB;
   localparam logic [3:0]  DASH_CODE  = 4'hA;
   localparam logic [15:0] BLANK_WORD = {4{BLANK_CODE}};

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: finds the first set bit of req starting
// at index 'start' and wrapping around past N_SRC-1 back to 0.
//   req   in  N_SRC  request vector
//   start in  IW     index examined first
//   any   out 1      at least one request bit is set
//   idx   out IW     index of the winning request (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N_SRC = 4,
   parameter int IW    = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IW-1:0]    start,
   output logic             any,
   output logic [IW-1:0]    idx
);

   // Offset k from the start position, folded back into 0..N_SRC-1.
   function automatic logic [IW-1:0] wrapIdx(input logic [IW-1:0] s, input int k);
      int j;
      j = int'(s) + k;
      if (j >= N_SRC) j = j - N_SRC;
      return IW'(j);
   endfunction

   // Walk the candidates from the farthest offset back to the start so the
   // last hit written is the one closest to 'start' in wrap order.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (req[wrapIdx(start, k)]) begin
            any = 1'b1;
            idx = wrapIdx(start, k);
         end
      end
   end

endmodule

// File: rtl/seg_display_sched.sv
// ---------------------------------------------------------------------------
// seg_display_sched
// Time-shares the 4-digit seven-segment scan driver between N_SRC requesters.
// Round-robin arbitration, each grant held for DWELL ticks unless the owner
// lets go, optional per-source blinking, blank word when nobody is shown.
//   clk190hz in  1         scan clock, rising edge
//   rst      in  1         synchronous active-high reset
//   req      in  N_SRC     level requests, held while a source wants display
//   blink_en in  N_SRC     owner blinks while granted
//   src_data in  16*N_SRC  source i nibble word at [16*i+15:16*i]
//   grant    out N_SRC     one-hot owner, zero when idle
//   done     out N_SRC     one-tick pulse to the owner in its last dwell tick
//   dataBus  out 16        registered word to the scan driver
// ---------------------------------------------------------------------------
module seg_display_sched
   import seg_pkg::*;
#(
   parameter int          N_SRC      = 4,
   parameter int          DWELL      = 190,
   parameter int          BLINK_HALF = 48,
   parameter logic [15:0] BLANK      = BLANK_WORD
) (
   input  logic                  clk190hz,
   input  logic                  rst,
   input  logic [N_SRC-1:0]      req,
   input  logic [N_SRC-1:0]      blink_en,
   input  logic [16*N_SRC-1:0]   src_data,
   output logic [N_SRC-1:0]      grant,
   output logic [N_SRC-1:0]      done,
   output logic [15:0]           dataBus
);

   localparam int IW = $clog2(N_SRC);
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [IW-1:0] LAST_IDX   = IW'(N_SRC - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   state_t          state,    stateN;
   logic [IW-1:0]   last,     lastN;
   logic [DW-1:0]   dwellCnt, dwellN;
   logic [BW-1:0]   blinkCnt, blinkCntN;
   logic            blinkPh,  blinkPhN;
   logic [N_SRC-1:0] grantN;
   logic [15:0]     dataN;

   logic [IW-1:0]   startIdx;
   logic            pickAny;
   logic [IW-1:0]   pickIdx;
   logic            dwellEnd;

   // While showing, 'last' is the current owner, so searching from last+1
   // serves both the idle pick and the end-of-dwell re-arbitration (the owner
   // itself is examined last, so it only keeps the display if alone).
   assign startIdx = (last == LAST_IDX) ? '0 : last + 1'b1;

   rr_pick #(
      .N_SRC (N_SRC),
      .IW    (IW)
   ) picker (
      .req   (req),
      .start (startIdx),
      .any   (pickAny),
      .idx   (pickIdx)
   );

   assign dwellEnd = (state == SHOW) && req[last] && (dwellCnt == DWELL_LAST);

   // done is decoded from the registered grant during the owner's final dwell
   // tick, so it can never appear without the matching grant bit; a reset in
   // that same tick suppresses it.
   always_comb begin
      done = '0;
      if (dwellEnd && !rst) done = grant;
   end

   // Next-state computation: arbitration, dwell counting, blink phase and the
   // bus word that goes with the next-state owner. Blink runs freely but is
   // restarted visible on every new grant, including a re-grant to the same
   // source.
   always_comb begin
      stateN    = state;
      lastN     = last;
      dwellN    = dwellCnt;
      grantN    = '0;
      dataN     = BLANK;
      if (blinkCnt == BLINK_LAST) begin
         blinkCntN = '0;
         blinkPhN  = ~blinkPh;
      end else begin
         blinkCntN = blinkCnt + 1'b1;
         blinkPhN  = blinkPh;
      end

      case (state)
         IDLE: begin
            if (pickAny) begin
               stateN    = SHOW;
               lastN     = pickIdx;
               dwellN    = '0;
               blinkCntN = '0;
               blinkPhN  = 1'b1;
            end
         end
         SHOW: begin
            if (!req[last]) begin
               stateN = IDLE;
               dwellN = '0;
            end else if (dwellCnt == DWELL_LAST) begin
               lastN     = pickIdx;
               dwellN    = '0;
               blinkCntN = '0;
               blinkPhN  = 1'b1;
            end else begin
               dwellN = dwellCnt + 1'b1;
            end
         end
         default: begin
            stateN = IDLE;
         end
      endcase

      if (stateN == SHOW) begin
         grantN[lastN] = 1'b1;
         if (!(blink_en[lastN] && !blinkPhN)) dataN = src_data[int'(lastN) * 16 +: 16];
      end
   end

   // State and output registers; reset restores the idle, blank, visible-phase
   // condition with the search pointer parked so src0 is tried first.
   always_ff @(posedge clk190hz) begin
      if (rst) begin
         state    <= IDLE;
         last     <= LAST_IDX;
         dwellCnt <= '0;
         blinkCnt <= '0;
         blinkPh  <= 1'b1;
         grant    <= '0;
         dataBus  <= BLANK;
      end else begin
         state    <= stateN;
         last     <= lastN;
         dwellCnt <= dwellN;
         blinkCnt <= blinkCntN;
         blinkPh  <= blinkPhN;
         grant    <= grantN;
         dataBus  <= dataN;
      end
   end

endmodule
